// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
// Holds the control FSM state encodings, the cascade seed values used when a
// compare starts (kept here so any parallel tree built from the same slice
// uses identical seeds), and a helper that derives "less than" from the
// (eq, gt) cascade pair.
package serial_magnitude_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Cascade seeds: "equal so far, not greater" lets the MSB slice decide.
  localparam logic EQ_SEED = 1'b1;
  localparam logic GT_SEED = 1'b0;

  // Less-than is the remaining outcome once neither equal nor greater.
  function automatic logic lt_of(input logic eq_v, input logic gt_v);
    return ~eq_v & ~gt_v;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_two_bit_comparator.sv
// Two-bit cascadable magnitude comparator slice.
// Ports:
//   a, b     : 2-bit operand digits for this slice
//   eq_in    : higher-order digits compared equal so far
//   gt_in    : higher-order digits already found a > b
//   eq_out   : result equal after including this slice
//   gt_out   : result greater after including this slice
// When the higher-order digits already resolved the order, that decision is
// passed through unchanged; otherwise this slice decides.
module two_bit_comparator (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       eq_in,
  input  logic       gt_in,
  output logic       eq_out,
  output logic       gt_out
);

  // Slice decision with cascade pass-through
  always_comb begin
    eq_out = eq_in;
    gt_out = gt_in;
    if (eq_in) begin
      eq_out = (a == b);
      gt_out = (a > b);
    end else begin
      eq_out = eq_in;
      gt_out = gt_in;
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB-first, two
// bits per cycle, through a single cascade slice, stopping as soon as the
// order is known.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-low reset
//   start      : request, taken only while idle (busy = 0)
//   is_signed  : 1 = two's-complement compare, 0 = unsigned (captured)
//   A, B       : operands (captured on an accepted start)
//   busy       : high while running or presenting the result
//   done       : one-cycle pulse, results valid
//   eq, gt, lt : compare result, held until the next accepted start
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;

  state_t           state_r;
  logic [WIDTH-1:0] sha_r;
  logic [WIDTH-1:0] shb_r;
  logic [CW-1:0]    cnt_r;
  logic             eq_r;
  logic             gt_r;
  logic             lt_r;
  logic             busy_r;
  logic             done_r;
  logic             slice_eq_s;
  logic             slice_gt_s;
  logic [WIDTH-1:0] sign_flip_s;

  // Flipping the sign bit of both operands maps two's complement onto
  // offset binary, so one unsigned slice serves both compare modes.
  assign sign_flip_s = {is_signed, {(WIDTH-1){1'b0}}};

  two_bit_comparator u_slice (
    .a      (sha_r[WIDTH-1:WIDTH-2]),
    .b      (shb_r[WIDTH-1:WIDTH-2]),
    .eq_in  (eq_r),
    .gt_in  (gt_r),
    .eq_out (slice_eq_s),
    .gt_out (slice_gt_s)
  );

  // Control FSM, shift registers, step counter and registered results
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
      sha_r   <= '0;
      shb_r   <= '0;
      cnt_r   <= '0;
      eq_r    <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sha_r   <= A ^ sign_flip_s;
            shb_r   <= B ^ sign_flip_s;
            cnt_r   <= CW'(N);
            eq_r    <= EQ_SEED;
            gt_r    <= GT_SEED;
            lt_r    <= lt_of(EQ_SEED, GT_SEED);
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          eq_r  <= slice_eq_s;
          gt_r  <= slice_gt_s;
          lt_r  <= lt_of(slice_eq_s, slice_gt_s);
          sha_r <= sha_r << 2;
          shb_r <= shb_r << 2;
          cnt_r <= cnt_r - CW'(1);
          // Stop once the order is known or the last slice was consumed.
          if (!slice_eq_s || (cnt_r == CW'(1))) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign eq   = eq_r;
  assign gt   = gt_r;
  assign lt   = lt_r;

endmodule
